// File: rtl/quad_encoder_frontend_pkg.sv
// Shared constants for the quadrature encoder / pushbutton front end.
// Holds the decode-resolution and press-class encodings, the direction
// codes, and the helper that gives the clockwise successor of an {A,B} state.
package quad_encoder_frontend_pkg;

  typedef enum logic [1:0] {
    MODE_X1 = 2'b00,
    MODE_X2 = 2'b01,
    MODE_X4 = 2'b10
  } mode_e;

  typedef enum logic [1:0] {
    PRESS_NONE   = 2'b00,
    PRESS_SHORT  = 2'b01,
    PRESS_NORMAL = 2'b10,
    PRESS_LONG   = 2'b11
  } press_e;

  localparam logic DIR_CW  = 1'b1;
  localparam logic DIR_CCW = 1'b0;

  // Clockwise order is 00 -> 10 -> 11 -> 01 -> 00.
  function automatic logic [1:0] cw_next(input logic [1:0] s);
    logic [1:0] n;
    case (s)
      2'b00:   n = 2'b10;
      2'b10:   n = 2'b11;
      2'b11:   n = 2'b01;
      default: n = 2'b00;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/quad_encoder_frontend_sync_debounce.sv
// Purpose: 1-bit synchroniser followed by a stability filter for a board pin.
// Latency: SYNC_STAGES+DEB_CYCLES edges from a stable pin change to dout; no backpressure.
// Ports: clk, rstn (sync, active-low), din (async pin), dout (filtered level).
module sync_debounce #(
  parameter int   SYNC_STAGES = 2,
  parameter int   DEB_CYCLES  = 4,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic dout
);

  localparam int RUN_W = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(DEB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   filt_q, filt_d;
  logic [RUN_W-1:0]       run_q, run_d;
  logic                   mismatch;

  assign mismatch = sync_q[SYNC_STAGES-1] ^ filt_q;

  // run_q counts consecutive mismatching cycles already seen; the filtered
  // level flips on the edge that closes the DEB_CYCLES-th such cycle.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    filt_d = filt_q;
    run_d  = '0;
    if (mismatch) begin
      if (run_q == RUN_LAST) begin
        filt_d = sync_q[SYNC_STAGES-1];
      end else begin
        run_d = run_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      filt_q <= RESET_VAL;
      run_q  <= '0;
    end else begin
      sync_q <= sync_d;
      filt_q <= filt_d;
      run_q  <= run_d;
    end
  end

  assign dout = filt_q;

endmodule

// File: rtl/quad_encoder_frontend.sv
// Purpose: quadrature decoder (x1/x2/x4, wrap or saturate) plus pushbutton press classifier.
// Latency: SYNC_STAGES+DEB_CYCLES+1 edges pin-to-pulse; free-running, no backpressure.
// Ports: a/b/pb pins, mode, clr in; count, step_valid/step_dir, err, press_valid/press_type, pb_held out.
module quad_encoder_frontend
  import quad_encoder_frontend_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4,
  parameter int PB_CNT_W    = 12,
  parameter int T_SHORT     = 50,
  parameter int T_NORMAL    = 400,
  parameter int T_LONG      = 1200,
  parameter int WRAP        = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             a,
  input  logic             b,
  input  logic             pb,
  input  logic [1:0]       mode,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             step_valid,
  output logic             step_dir,
  output logic             err,
  output logic             press_valid,
  output logic [1:0]       press_type,
  output logic             pb_held
);

  localparam int WARM   = SYNC_STAGES + DEB_CYCLES + 1;
  localparam int WARM_W = $clog2(WARM + 1);
  localparam logic [WARM_W-1:0]   WARM_DONE  = WARM_W'(WARM);
  localparam logic [CNT_W-1:0]    CNT_MAX    = '1;
  localparam logic [PB_CNT_W-1:0] PB_MAX     = '1;
  localparam logic [PB_CNT_W-1:0] T_SHORT_C  = PB_CNT_W'(T_SHORT);
  localparam logic [PB_CNT_W-1:0] T_NORMAL_C = PB_CNT_W'(T_NORMAL);
  localparam logic [PB_CNT_W-1:0] T_LONG_C   = PB_CNT_W'(T_LONG);

  logic a_f, b_f, pb_f;

  sync_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEB_CYCLES(DEB_CYCLES), .RESET_VAL(1'b0))
    u_sync_a  (.clk(clk), .rstn(rstn), .din(a),  .dout(a_f));
  sync_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEB_CYCLES(DEB_CYCLES), .RESET_VAL(1'b0))
    u_sync_b  (.clk(clk), .rstn(rstn), .din(b),  .dout(b_f));
  sync_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEB_CYCLES(DEB_CYCLES), .RESET_VAL(1'b1))
    u_sync_pb (.clk(clk), .rstn(rstn), .din(pb), .dout(pb_f));

  logic [WARM_W-1:0]   warm_q, warm_d;
  logic [1:0]          prev_q, prev_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                step_vld_q, step_vld_d;
  logic                step_dir_q, step_dir_d;
  logic                err_q, err_d;
  logic                pb_prev_q, pb_prev_d;
  logic [PB_CNT_W-1:0] pcnt_q, pcnt_d;
  logic                held_q, held_d;
  logic                pv_q, pv_d;
  logic [1:0]          ptype_q, ptype_d;

  logic       armed;
  logic [1:0] cur;
  logic       cw;
  logic       take;

  // Warm-up covers the filter flush after reset so pins already away from
  // their reset level only seed prev_q instead of producing steps.
  assign armed = (warm_q == WARM_DONE);
  assign cur   = {a_f, b_f};

  always_comb begin
    warm_d     = armed ? warm_q : warm_q + 1'b1;
    prev_d     = cur;
    cw         = (cw_next(prev_q) == cur);
    step_vld_d = 1'b0;
    step_dir_d = step_dir_q;
    err_d      = 1'b0;
    count_d    = count_q;

    // Resolution is chosen by which state the transition leaves.
    if (mode == MODE_X1) begin
      take = (prev_q == 2'b00);
    end else if (mode == MODE_X2) begin
      take = (prev_q == 2'b00) || (prev_q == 2'b11);
    end else begin
      take = 1'b1;
    end

    if (armed && (cur != prev_q)) begin
      if ((cur ^ prev_q) == 2'b11) begin
        err_d = 1'b1;
      end else if (take) begin
        step_vld_d = 1'b1;
        step_dir_d = cw ? DIR_CW : DIR_CCW;
        if (cw) begin
          count_d = ((WRAP == 0) && (count_q == CNT_MAX)) ? count_q : count_q + 1'b1;
        end else begin
          count_d = ((WRAP == 0) && (count_q == '0)) ? count_q : count_q - 1'b1;
        end
      end
    end

    // clr wins over the count update but the step is still reported.
    if (clr) begin
      count_d = '0;
    end
  end

  always_comb begin
    pb_prev_d = pb_f;
    pcnt_d    = pcnt_q;
    held_d    = held_q;
    pv_d      = 1'b0;
    ptype_d   = ptype_q;
    if (!pb_prev_q && pb_f) begin
      // Release: classify on the accumulated hold time, then start afresh.
      pcnt_d = '0;
      held_d = 1'b0;
      if (pcnt_q >= T_LONG_C) begin
        pv_d    = 1'b1;
        ptype_d = PRESS_LONG;
      end else if (pcnt_q >= T_NORMAL_C) begin
        pv_d    = 1'b1;
        ptype_d = PRESS_NORMAL;
      end else if (pcnt_q >= T_SHORT_C) begin
        pv_d    = 1'b1;
        ptype_d = PRESS_SHORT;
      end
    end else if (!pb_f && armed) begin
      if (pcnt_q != PB_MAX) begin
        pcnt_d = pcnt_q + 1'b1;
      end
      if (pcnt_d >= T_LONG_C) begin
        held_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      warm_q     <= '0;
      prev_q     <= 2'b00;
      count_q    <= '0;
      step_vld_q <= 1'b0;
      step_dir_q <= 1'b0;
      err_q      <= 1'b0;
      pb_prev_q  <= 1'b1;
      pcnt_q     <= '0;
      held_q     <= 1'b0;
      pv_q       <= 1'b0;
      ptype_q    <= 2'b00;
    end else begin
      warm_q     <= warm_d;
      prev_q     <= prev_d;
      count_q    <= count_d;
      step_vld_q <= step_vld_d;
      step_dir_q <= step_dir_d;
      err_q      <= err_d;
      pb_prev_q  <= pb_prev_d;
      pcnt_q     <= pcnt_d;
      held_q     <= held_d;
      pv_q       <= pv_d;
      ptype_q    <= ptype_d;
    end
  end

  assign count       = count_q;
  assign step_valid  = step_vld_q;
  assign step_dir    = step_dir_q;
  assign err         = err_q;
  assign press_valid = pv_q;
  assign press_type  = ptype_q;
  assign pb_held     = held_q;

endmodule

// File: doc/quad_encoder_frontend.md
Name: quad_encoder_frontend

Overview:
- Parametrised successor to the single-purpose rotary encoder/pushbutton input block.
- Synchronises and debounces quadrature channels A/B and a pushbutton.
- Decodes in x1/x2/x4 resolution into a CNT_W-bit position counter, with wrap or saturate behaviour.
- Reports every qualified button press as a one-cycle classified event, plus a live long-hold flag. Sits between board pins and the menu/control logic.

Parameters:
CNT_W, 8, position counter width (>=2)
SYNC_STAGES, 2, synchroniser flops per input (>=2)
DEB_CYCLES, 4, consecutive stable cycles required to accept an input change (>=1)
PB_CNT_W, 12, press-duration counter width
T_SHORT, 50, minimum cycles for a valid press
T_NORMAL, 400, normal-press threshold
T_LONG, 1200, long-press threshold (T_SHORT<T_NORMAL<T_LONG<=2^PB_CNT_W-1)
WRAP, 1, 1 = count wraps modulo 2^CNT_W; 0 = saturate at 0 and 2^CNT_W-1

Ports:
clk  in  1  system clock
rstn  in  1  reset; one clock, synchronous, active-low
a  in  1  encoder channel A (asynchronous pin)
b  in  1  encoder channel B (asynchronous pin)
pb  in  1  pushbutton, active-low (asynchronous pin)
mode  in  2  decode resolution: 00 = x1, 01 = x2, 10 = x4, 11 = x4
clr  in  1  synchronous clear of count
count  out  CNT_W  position value
step_valid  out  1  one-cycle pulse per counted step
step_dir  out  1  direction of the step: 1 = CW (up), 0 = CCW (down); valid with step_valid
err  out  1  one-cycle pulse on an illegal transition (A and B change together)
press_valid  out  1  one-cycle pulse on classified release
press_type  out  2  01 short, 10 normal, 11 long; holds last value
pb_held  out  1  high while the button is held and the press count >= T_LONG

Behaviour:
- Reset (rstn=0 at a clk edge): all outputs 0. Synchroniser and filter state go to a=0, b=0, pb=1. Press counter 0. Warm-up counter 0.
- Filter (per input): the synchronised sample must differ from the filtered value for DEB_CYCLES consecutive cycles; the filtered value then updates on the next edge. Any intermediate mismatch-then-match restarts the run count.
- Warm-up: for SYNC_STAGES+DEB_CYCLES+1 cycles after reset the decoder and press logic are not armed.
  - Filtered a/b changes seed the previous state only; no step, no err.
  - The press counter does not run.
- Decoder: the previous state {A,B} is compared with the filtered state each cycle.
  - CW sequence: 00→10→11→01→00. CCW is the reverse.
  - x4: every legal transition counts.
  - x2: only transitions leaving 00 or 11 count.
  - x1: only transitions leaving 00 count.
  - A diagonal transition (00↔11, 10↔01) pulses err, does not count, and updates the previous state.
- Step output: step_valid/step_dir are registered and assert on the edge after the filtered transition. count updates on that same edge. Pin-to-step latency is SYNC_STAGES+DEB_CYCLES+1 cycles after a stable pin change.
- Count arithmetic:
  - CW adds 1, CCW subtracts 1.
  - WRAP=1: modulo 2^CNT_W, so 0−1 = 2^CNT_W−1.
  - WRAP=0: clamps at the limits, and step_valid still pulses at a limit.
- clr: count=0 on the next edge and takes priority over a simultaneous step. step_valid/step_dir/err still report that step.
- mode change: takes effect on the next transition; count is not adjusted.
- Press counting: while filtered pb=0 and armed, the counter increments each cycle, saturating at 2^PB_CNT_W−1. pb_held goes to 1 on the edge where the counter reaches T_LONG.
- Release (filtered pb 0→1), on the next edge:
  - cnt < T_SHORT: no pulse (glitch), press_type unchanged.
  - [T_SHORT,T_NORMAL): 01.
  - [T_NORMAL,T_LONG): 10.
  - >= T_LONG: 11.
  - press_valid pulses for one cycle, and the counter and pb_held clear.
  - Every press is reported, including repeats of the same type.
- Encoder and button paths are independent; simultaneous events are both reported in the same cycle.
- Reset mid-operation: an in-progress press is discarded without a pulse, count clears, and the block re-enters warm-up.

Decomposition:
- Shared package:
  - mode encodings (MODE_X1/X2/X4)
  - press type constants (PRESS_NONE/SHORT/NORMAL/LONG)
  - direction constants (DIR_CW/DIR_CCW)
- One sub-module, sync_debounce: a 1-bit synchroniser plus stability filter with parameters SYNC_STAGES, DEB_CYCLES and RESET_VAL. It is instantiated three times (a, b, pb).

Test Plan:
- x4, WRAP=1, CNT_W=8, count=255, one full CW cycle 00→10→11→01→00 (each state held 10 cycles) → four step_valid pulses with dir=1; count 255→0→1→2→3; first pulse exactly SYNC_STAGES+DEB_CYCLES+1 cycles after the pin edge.
- x1 then x2, one CCW cycle each from count=10 → x1 gives count 9 (one pulse); x2 gives two pulses, 9→7. WRAP=0 at count=0 with CCW → count stays 0 and step_valid pulses.
- Glitch on a shorter than DEB_CYCLES (3 cycles) → no filtered change, no step. Diagonal 00→11 held stable → err pulse, count unchanged.
- pb low 30, 200, 800 and 3000 cycles, each followed by release → no pulse, then 01, 10 and 11 respectively. pb_held rises at cycle 1200 of the 3000-cycle press. Two consecutive 200-cycle presses → two press_valid pulses, both 01.
- clr asserted in the same cycle as a CW step at count=5 → count=0, step_valid=1.
- rstn asserted mid-press at cycle 500 → no press_valid. With pins at a=b=1 during reset, release rstn → no step and no err during warm-up.
